// File: rtl/beep_sequencer.sv
// beep_sequencer: plays a programmable train of beeps on o_beep_en after a
// one-cycle start request. On/off durations are counted in prescaler ticks
// of DIV system clocks each, so every output is a clean registered level.

module beep_sequencer #(
  parameter int unsigned DIV = 100
) (
  input  logic       i_clock,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [3:0] i_count,
  input  logic [7:0] i_on_ticks,
  input  logic [7:0] i_off_ticks,
  output logic       o_beep_en,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [TICK_W-1:0] r_presc;
  logic [7:0]        r_phase;
  logic [7:0]        r_on_len;
  logic [7:0]        r_off_len;
  logic [3:0]        r_rem;

  logic              w_tick;
  logic [7:0]        w_phase_nxt;
  logic [7:0]        w_on_len_in;
  logic [7:0]        w_off_len_in;
  logic              w_start_ok;
  logic [TICK_W-1:0] w_presc_nxt;

  // Tick on the last prescaler count; phase compare uses the post-increment value.
  assign w_tick       = (r_presc == TICK_W'(DIV - 1));
  assign w_presc_nxt  = w_tick ? '0 : r_presc + TICK_W'(1);
  assign w_phase_nxt  = r_phase + 8'd1;
  assign w_on_len_in  = (i_on_ticks  == 8'd0) ? 8'd1 : i_on_ticks;
  assign w_off_len_in = (i_off_ticks == 8'd0) ? 8'd1 : i_off_ticks;
  assign w_start_ok   = i_start && !i_abort && (i_count != 4'd0);

  // Sequencer FSM with prescaler, phase/remaining counters and registered outputs.
  always_ff @(posedge i_clock or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_phase   <= 8'd0;
      r_on_len  <= 8'd0;
      r_off_len <= 8'd0;
      r_rem     <= 4'd0;
      o_beep_en <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          if (w_start_ok) begin
            r_rem     <= i_count;
            r_on_len  <= w_on_len_in;
            r_off_len <= w_off_len_in;
            r_phase   <= 8'd0;
            r_state   <= S_ON;
            o_beep_en <= 1'b1;
            o_busy    <= 1'b1;
          end
        end

        S_ON: begin
          if (i_abort) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_phase   <= 8'd0;
            r_rem     <= 4'd0;
            r_on_len  <= 8'd0;
            r_off_len <= 8'd0;
            o_beep_en <= 1'b0;
            o_busy    <= 1'b0;
          end else begin
            r_presc <= w_presc_nxt;
            if (w_tick) begin
              if (w_phase_nxt == r_on_len) begin
                r_phase   <= 8'd0;
                o_beep_en <= 1'b0;
                if (r_rem == 4'd1) begin
                  r_state <= S_DONE;
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                end else begin
                  r_state <= S_OFF;
                end
              end else begin
                r_phase <= w_phase_nxt;
              end
            end
          end
        end

        S_OFF: begin
          if (i_abort) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_phase   <= 8'd0;
            r_rem     <= 4'd0;
            r_on_len  <= 8'd0;
            r_off_len <= 8'd0;
            o_beep_en <= 1'b0;
            o_busy    <= 1'b0;
          end else begin
            r_presc <= w_presc_nxt;
            if (w_tick) begin
              if (w_phase_nxt == r_off_len) begin
                r_phase   <= 8'd0;
                r_rem     <= r_rem - 4'd1;
                r_state   <= S_ON;
                o_beep_en <= 1'b1;
              end else begin
                r_phase <= w_phase_nxt;
              end
            end
          end
        end

        S_DONE: begin
          // Single-cycle completion state; start is deliberately not sampled here.
          r_state   <= S_IDLE;
          r_presc   <= '0;
          r_phase   <= 8'd0;
          r_rem     <= 4'd0;
          o_beep_en <= 1'b0;
          o_busy    <= 1'b0;
        end

        default: begin
          r_state   <= S_IDLE;
          r_presc   <= '0;
          r_phase   <= 8'd0;
          r_rem     <= 4'd0;
          o_beep_en <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed self-checking bench for beep_sequencer with DIV=4.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_beep_sequencer;

  localparam int unsigned DIV = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] count;
  logic [7:0] on_ticks;
  logic [7:0] off_ticks;
  logic       beep_en;
  logic       busy;
  logic       done;

  int n_checks;
  int n_err;

  beep_sequencer #(.DIV(DIV)) dut (
    .i_clock     (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_abort     (abort),
    .i_count     (count),
    .i_on_ticks  (on_ticks),
    .i_off_ticks (off_ticks),
    .o_beep_en   (beep_en),
    .o_busy      (busy),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".beep_en"}, beep_en, 1'b0);
    check({tag, ".busy"},    busy,    1'b0);
    check({tag, ".done"},    done,    1'b0);
  endtask

  // Plays one full pattern starting at the current falling edge.
  // on_c/off_c are the expected on/off durations in clock cycles.
  // mode 1: re-pulse start mid-pattern; 2: change on_ticks to 7 during
  // beep 1; 3: pulse start in the done cycle.
  task automatic play(input string name, input logic [3:0] cnt,
                      input logic [7:0] on_t, input logic [7:0] off_t,
                      input int on_c, input int off_c, input int mode);
    int total;
    int pos;
    logic exp_beep;
    total     = int'(cnt) * on_c + (int'(cnt) - 1) * off_c;
    start     = 1'b1;
    count     = cnt;
    on_ticks  = on_t;
    off_ticks = off_t;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      pos      = (c - 1) % (on_c + off_c);
      exp_beep = (pos < on_c);
      check($sformatf("%s.c%0d.beep_en", name, c), beep_en, exp_beep);
      check($sformatf("%s.c%0d.busy", name, c), busy, 1'b1);
      check($sformatf("%s.c%0d.done", name, c), done, 1'b0);
      start = (mode == 1 && (c == 3 || c == on_c + 2));
      if (mode == 2 && c == 3) on_ticks = 8'd7;
    end
    @(negedge clk);
    check({name, ".done_pulse"}, done,    1'b1);
    check({name, ".done_busy"},  busy,    1'b0);
    check({name, ".done_beep"},  beep_en, 1'b0);
    start = (mode == 3);
    @(negedge clk);
    check_idle({name, ".after1"});
    start = 1'b0;
    @(negedge clk);
    check_idle({name, ".after2"});
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    rst       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    count     = 4'd0;
    on_ticks  = 8'd0;
    off_ticks = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Basic pattern: 3 beeps, on=2 ticks (8 cycles), off=1 tick (4 cycles)
    play("basic", 4'd3, 8'd2, 8'd1, 8, 4, 0);

    // count=0 start is ignored
    start = 1'b1; count = 4'd0; on_ticks = 8'd2; off_ticks = 8'd1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check_idle($sformatf("count0.c%0d", c));
      @(negedge clk);
    end

    // count=1, zero lengths treated as 1 tick
    play("zero_len", 4'd1, 8'd0, 8'd0, 4, 4, 0);

    // Abort during the second OFF (cycles 37..48 of count=5, on=off=12)
    start = 1'b1; count = 4'd5; on_ticks = 8'd3; off_ticks = 8'd3;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("abort.c%0d.beep_en", c), beep_en, (((c - 1) % 24) < 12));
      check($sformatf("abort.c%0d.busy", c), busy, 1'b1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort.next");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_idle($sformatf("abort.idle%0d", c));
    end

    // Fresh full pattern after abort
    play("after_abort", 4'd5, 8'd3, 8'd3, 12, 12, 0);

    // start re-pulsed while busy: length unchanged
    play("restart", 4'd2, 8'd2, 8'd1, 8, 4, 1);

    // start together with abort in IDLE: nothing starts
    start = 1'b1; abort = 1'b1; count = 4'd3; on_ticks = 8'd1; off_ticks = 8'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_idle("start_abort.c1");
    @(negedge clk);
    check_idle("start_abort.c2");

    // start in the DONE cycle is ignored
    play("start_in_done", 4'd1, 8'd1, 8'd1, 4, 4, 3);

    // Latched on length: on_ticks change mid-pattern has no effect
    play("latch", 4'd2, 8'd2, 8'd1, 8, 4, 2);

    // Asynchronous reset in the middle of a beep
    start = 1'b1; count = 4'd2; on_ticks = 8'd2; off_ticks = 8'd1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("areset.pre_beep", beep_en, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("areset.async_beep", beep_en, 1'b0);
    check("areset.async_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_idle($sformatf("areset.idle%0d", c));
    end

    // Block restarts cleanly after reset
    play("post_areset", 4'd2, 8'd1, 8'd2, 4, 8, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/beep_sequencer.md
Name: beep_sequencer

Overview:
- Upstream controller for the Beeper stage; drives its open enable input.
- On a start strobe, plays N beeps with programmable on/off durations.
- Durations are timed by an internal tick prescaler on the system clock, so beep_en is a clean, glitch-free synchronous level.
- Used for alarm and chime patterns (e.g. hourly chime = N beeps).

Parameters:
- DIV, 8'd100 (any value >= 2): system clock cycles per timing tick; tick_w = clog2(DIV).

Ports:
- clock  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- start  input  1  one-cycle request; sampled only in IDLE.
- abort  input  1  stop pattern immediately.
- count  input  4  number of beeps, 1..15; 0 = request ignored.
- on_ticks  input  8  beep-on length in ticks; 0 treated as 1.
- off_ticks  input  8  gap length in ticks; 0 treated as 1.
- beep_en  output  1  to Beeper open input; high while a beep sounds.
- busy  output  1  high in ON/OFF states.
- done  output  1  one-cycle pulse when a pattern completes normally.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; beep_en=0, busy=0, done=0.
  - Prescaler, phase counter, remaining counter and latched lengths all cleared.
- All outputs are registered (no combinational path from inputs).
- States: IDLE, ON, OFF, DONE.
- IDLE:
  - If start=1, abort=0 and count!=0: latch rem=count, on_len=max(on_ticks,1), off_len=max(off_ticks,1).
  - Clear prescaler and phase counter, go to ON.
  - The cycle after start is sampled: beep_en=1, busy=1.
  - start with count=0 is ignored: stays IDLE, no done pulse.
- Prescaler:
  - Counts 0..DIV-1 while in ON/OFF, held at 0 otherwise.
  - tick is asserted on the cycle the prescaler equals DIV-1, then it wraps to 0.
- ON (beep_en=1):
  - Phase counter increments on tick.
  - On the tick where phase reaches on_len: clear phase; if rem==1 go to DONE, else go to OFF.
  - Each ON lasts exactly on_len*DIV cycles.
- OFF (beep_en=0, busy=1):
  - On the tick where phase reaches off_len: clear phase, rem=rem-1, go to ON.
  - Each OFF lasts exactly off_len*DIV cycles.
- DONE:
  - done=1, beep_en=0, busy=0 for exactly one cycle, then IDLE.
  - start is not sampled in DONE; it is ignored there.
- Total time from the first beep_en rise to the done pulse: count*on_len*DIV + (count-1)*off_len*DIV cycles.
- Inputs during a pattern:
  - start is ignored while busy.
  - count/on_ticks/off_ticks changes mid-pattern have no effect (latched values are used).
- abort (any state except IDLE):
  - Next cycle: state=IDLE, beep_en=0, busy=0, done=0; counters cleared; no done pulse.
  - abort and start in the same IDLE cycle: abort wins, nothing starts.
- Reset asserted mid-pattern: beep_en drops asynchronously. After release, the block is IDLE and waits for a new start.
- Widths:
  - Phase counter is 8 bits; compares against latched length, no overflow possible.
  - rem is 4 bits and never decrements below 1.

Test Plan:
- Basic pattern, DIV=4, count=3, on=2, off=1, start pulse:
  - beep_en: high 8 cycles, low 4, high 8, low 4, high 8.
  - Then done=1 for 1 cycle; busy high from the cycle after start until done.
- Zero handling, DIV=4:
  - count=0 with start: no activity, done never pulses.
  - count=1, on=0, off=0: beep_en high exactly 4 cycles, then done.
- Abort, DIV=4, count=5, on=3, off=3:
  - Assert abort during the second OFF: next cycle busy=0, beep_en=0, no done.
  - A new start afterwards plays a full fresh pattern.
- Start collisions:
  - start re-pulsed while busy: pattern length unchanged.
  - start with abort in IDLE: nothing starts.
  - start in the DONE cycle: ignored.
- Async reset mid-ON (rst=0 between clock edges): beep_en falls without waiting for a clock edge; after release the block is IDLE.
- Latching: change on_ticks from 2 to 7 during the first beep (count=2, DIV=4); the second beep still lasts 8 cycles.
